keypad_pw_assembler: RTL and testbench

- Keypad-side front end of the password lock: collects BCD digit key strobes into the 16-bit entry word `pw_16bit` and issues the single-cycle compare strobe `enb_cmp`.
- Its outputs feed the `pw_16bit` / `enb_cmp` inputs of the checking/error-processing path.
- Honours the lockout `gen_stop` coming back from that path.
- Provides edit keys (backspace, clear) and an inactivity timeout.

---
 rtl/lock_pkg.sv | 20 ++
 rtl/inactivity_timer.sv | 30 +++
 rtl/keypad_pw_assembler.sv | 112 +++++++++++
 tb/tb_keypad_pw_assembler.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared key codes, entry length and FSM state type for the password lock keypad path.
package lock_pkg;

   localparam logic [3:0] KEY_BKSP  = 4'hB;
   localparam logic [3:0] KEY_CLR   = 4'hC;
   localparam logic [3:0] KEY_ENT   = 4'hE;
   localparam int         PW_DIGITS = 4;

   typedef enum logic [1:0] {
      IDLE,
      ENTRY,
      FULL,
      SUBMIT
   } state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/inactivity_timer.sv
// Idle-cycle counter: counts while enabled, clears on restart, flags the last cycle of the window.
module inactivity_timer #(
   parameter int TIMEOUT_CYCLES = 100_000_000,
   parameter int TMR_W          = 27
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic restart,
   output logic expire
);

   localparam logic [TMR_W-1:0] LAST = TMR_W'(TIMEOUT_CYCLES - 1);

   logic [TMR_W-1:0] cnt_reg;

   // A coincident restart wins over expiry so a late key keeps the entry alive.
   assign expire = enable && !restart && (cnt_reg == LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else if (!enable || restart || expire) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/keypad_pw_assembler.sv
// Collects BCD key strobes into a 4-digit entry word and issues a one-cycle compare strobe.
module keypad_pw_assembler
   import lock_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 100_000_000,
   parameter int TMR_W          = 27
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   input  logic        gen_stop,
   output logic [15:0] pw_16bit,
   output logic        enb_cmp,
   output logic [2:0]  digit_count,
   output logic        timeout,
   output logic        entry_err
);

   state_t      state_reg;
   logic [15:0] pw_reg;
   logic [2:0]  count_reg;
   logic        enb_cmp_reg;
   logic        timeout_reg;
   logic        entry_err_reg;

   logic digit_ok;
   logic bksp_ok;
   logic clr_ok;
   logic ent_ok;
   logic key_event;
   logic tmr_enable;
   logic tmr_expire;

   // Only keys that actually change the entry count as activity.
   assign digit_ok  = key_valid && is_digit(key_code) && ((state_reg == IDLE) || (state_reg == ENTRY));
   assign bksp_ok   = key_valid && (key_code == KEY_BKSP) && ((state_reg == ENTRY) || (state_reg == FULL));
   assign clr_ok    = key_valid && (key_code == KEY_CLR) && (state_reg != SUBMIT);
   assign ent_ok    = key_valid && (key_code == KEY_ENT) && (state_reg != SUBMIT);
   assign key_event = digit_ok || bksp_ok || clr_ok || ent_ok;

   assign tmr_enable = !gen_stop && ((state_reg == ENTRY) || (state_reg == FULL));

   inactivity_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .TMR_W          (TMR_W)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .enable  (tmr_enable),
      .restart (key_event),
      .expire  (tmr_expire)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         pw_reg        <= 16'h0000;
         count_reg     <= 3'd0;
         enb_cmp_reg   <= 1'b0;
         timeout_reg   <= 1'b0;
         entry_err_reg <= 1'b0;
      end else begin
         enb_cmp_reg   <= 1'b0;
         timeout_reg   <= 1'b0;
         entry_err_reg <= 1'b0;
         if (gen_stop) begin
            state_reg <= IDLE;
            pw_reg    <= 16'h0000;
            count_reg <= 3'd0;
         end else if (state_reg == SUBMIT) begin
            // The submitted word stays on pw_16bit for downstream.
            state_reg <= IDLE;
            count_reg <= 3'd0;
         end else if (digit_ok) begin
            pw_reg    <= (state_reg == IDLE) ? {12'h000, key_code} : {pw_reg[11:0], key_code};
            count_reg <= count_reg + 3'd1;
            state_reg <= (count_reg == 3'(PW_DIGITS - 1)) ? FULL : ENTRY;
         end else if (bksp_ok) begin
            pw_reg    <= {4'h0, pw_reg[15:4]};
            count_reg <= count_reg - 3'd1;
            state_reg <= (count_reg == 3'd1) ? IDLE : ENTRY;
         end else if (clr_ok) begin
            state_reg <= IDLE;
            pw_reg    <= 16'h0000;
            count_reg <= 3'd0;
         end else if (ent_ok) begin
            if (state_reg == FULL) begin
               state_reg   <= SUBMIT;
               enb_cmp_reg <= 1'b1;
            end else begin
               state_reg     <= IDLE;
               pw_reg        <= 16'h0000;
               count_reg     <= 3'd0;
               entry_err_reg <= 1'b1;
            end
         end else if (tmr_expire) begin
            state_reg   <= IDLE;
            pw_reg      <= 16'h0000;
            count_reg   <= 3'd0;
            timeout_reg <= 1'b1;
         end
      end
   end

   assign pw_16bit    = pw_reg;
   assign digit_count = count_reg;
   assign enb_cmp     = enb_cmp_reg && !gen_stop;
   assign timeout     = timeout_reg;
   assign entry_err   = entry_err_reg;

endmodule

// File: tb/tb_keypad_pw_assembler.sv
// Directed plus randomized key sequences checked against a digit-queue model of the keypad entry.
module tb_keypad_pw_assembler;

   localparam int T = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        key_valid;
   logic [3:0]  key_code;
   logic        gen_stop;
   logic [15:0] pw_16bit;
   logic        enb_cmp;
   logic [2:0]  digit_count;
   logic        timeout;
   logic        entry_err;

   always #5 clk = ~clk;

   keypad_pw_assembler #(
      .TIMEOUT_CYCLES (T),
      .TMR_W          (5)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .gen_stop    (gen_stop),
      .pw_16bit    (pw_16bit),
      .enb_cmp     (enb_cmp),
      .digit_count (digit_count),
      .timeout     (timeout),
      .entry_err   (entry_err)
   );

   int vectors    = 0;
   int miscompares = 0;

   // Model: the typed digits as a queue, the displayed word, and cycles of silence.
   int          q[$];
   logic [15:0] exp_pw;
   bit          exp_enb, exp_to, exp_err, in_submit;
   int          quiet;

   function logic [15:0] compose();
      logic [15:0] w;
      w = 16'h0000;
      foreach (q[i]) w = (w << 4) | 16'(q[i]);
      return w;
   endfunction

   task model_reset();
      q.delete();
      exp_pw = 16'h0000;
      exp_enb = 0; exp_to = 0; exp_err = 0; in_submit = 0; quiet = 0;
   endtask

   task model_step(input bit v, input logic [3:0] c, input bit gs);
      bit accepted;
      exp_enb = 0; exp_to = 0; exp_err = 0; accepted = 0;
      if (gs) begin
         q.delete(); exp_pw = 16'h0000; in_submit = 0; quiet = 0;
      end else if (in_submit) begin
         q.delete(); in_submit = 0; quiet = 0;
      end else begin
         if (v) begin
            if (c <= 4'd9) begin
               if (q.size() < 4) begin q.push_back(int'(c)); exp_pw = compose(); accepted = 1; end
            end else if (c == 4'hB) begin
               if (q.size() > 0) begin void'(q.pop_back()); exp_pw = compose(); accepted = 1; end
            end else if (c == 4'hC) begin
               q.delete(); exp_pw = 16'h0000; accepted = 1;
            end else if (c == 4'hE) begin
               accepted = 1;
               if (q.size() == 4) begin in_submit = 1; exp_enb = 1; end
               else begin exp_err = 1; q.delete(); exp_pw = 16'h0000; end
            end
         end
         if (accepted) quiet = 0;
         else if (q.size() > 0) begin
            if (quiet == T - 1) begin
               exp_to = 1; q.delete(); exp_pw = 16'h0000; quiet = 0;
            end else quiet++;
         end else quiet = 0;
      end
   endtask

   task check(input string tag, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      assert (act === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   task check_all();
      check("pw_16bit", pw_16bit, exp_pw);
      check("digit_count", 16'(digit_count), 16'(q.size()));
      check("enb_cmp", 16'(enb_cmp), 16'(exp_enb));
      check("timeout", 16'(timeout), 16'(exp_to));
      check("entry_err", 16'(entry_err), 16'(exp_err));
   endtask

   task cycle(input bit v, input logic [3:0] c, input bit gs);
      key_valid = v; key_code = c; gen_stop = gs;
      @(posedge clk);
      model_step(v, c, gs);
      @(negedge clk);
      check_all();
      if (v) $display("t=%0t key %h gs %0d -> pw %h cnt %0d enb %0d to %0d err %0d",
                      $time, c, gs, pw_16bit, digit_count, enb_cmp, timeout, entry_err);
   endtask

   task key(input logic [3:0] c);
      cycle(1'b1, c, 1'b0);
   endtask

   task idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0);
   endtask

   logic [3:0] rc;
   int         sel;

   initial begin
      reset = 1'b1; key_valid = 1'b0; key_code = 4'h0; gen_stop = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      check_all();
      reset = 1'b0;

      // Basic submit.
      key(4'h1); key(4'h2); key(4'h3); key(4'h4);
      check("count_full", 16'(digit_count), 16'd4);
      key(4'hE);
      check("enb_on_submit", 16'(enb_cmp), 16'd1);
      idle(1);
      check("pw_hold", pw_16bit, 16'h1234);
      idle(2);

      // Fifth digit ignored when full.
      key(4'h5); key(4'h6); key(4'h7); key(4'h8); key(4'h9); key(4'hE);
      check("pw_submit2", pw_16bit, 16'h5678);
      idle(2);

      // Edit keys.
      key(4'h1); key(4'h2); key(4'h3); key(4'hB);
      check("pw_bksp", pw_16bit, 16'h0012);
      key(4'h7); key(4'h8);
      check("pw_edit", pw_16bit, 16'h1278);
      key(4'hC);
      idle(1);

      // Short enter.
      key(4'h4); key(4'h2); key(4'hE);
      check("err_pulse", 16'(entry_err), 16'd1);
      idle(1);

      // Inactivity: expire, then rescue at cycle 15.
      key(4'h3); idle(T - 1);
      check("no_to_yet", 16'(timeout), 16'd0);
      idle(1);
      check("to_pulse", 16'(timeout), 16'd1);
      idle(1);
      key(4'h3); idle(T - 2); key(4'h5); idle(T - 2);
      check("rescued_cnt", 16'(digit_count), 16'd2);
      key(4'hC);

      // Lockout.
      key(4'h1); key(4'h2);
      cycle(1'b0, 4'h0, 1'b1);
      check("lock_cnt", 16'(digit_count), 16'd0);
      cycle(1'b1, 4'h1, 1'b1); cycle(1'b1, 4'h2, 1'b1); cycle(1'b1, 4'h3, 1'b1);
      cycle(1'b1, 4'h4, 1'b1); cycle(1'b1, 4'hE, 1'b1); cycle(1'b0, 4'h0, 1'b1);
      idle(1);
      key(4'h9); key(4'h9); key(4'h9); key(4'h9); key(4'hE);
      check("pw_9999", pw_16bit, 16'h9999);
      idle(1);

      // Asynchronous reset mid-entry.
      key(4'h1); key(4'h2);
      #2 reset = 1'b1;
      #1 model_reset();
      check_all();
      @(negedge clk);
      reset = 1'b0;

      // Randomized traffic.
      for (int n = 0; n < 400; n++) begin
         sel = int'($urandom_range(0, 19));
         case (sel)
            12: rc = 4'hB; 13: rc = 4'hC; 14: rc = 4'hE; 15: rc = 4'hE;
            16: rc = 4'hA; 17: rc = 4'hD; 18: rc = 4'hF; 19: rc = 4'hB;
            default: rc = 4'(sel % 10);
         endcase
         if ($urandom_range(0, 39) == 0) idle(T + 1);
         cycle(1'($urandom_range(0, 1)), rc, ($urandom_range(0, 49) == 0));
      end
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
